// File: rtl/sr_mc_sequencer.sv
// Multi-cycle execution sequencer: latches operands, launches the unit, stalls the PC,
// lends the shared ALU to the unit, and issues one register-file write per instruction.
module sr_mc_sequencer #(
  parameter int OP_W    = 8,
  parameter int RES_W   = 9,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [4:0]       issue_rd,
  input  logic [OP_W-1:0]  issue_a,
  input  logic [OP_W-1:0]  issue_b,
  output logic             unit_start,
  output logic [OP_W-1:0]  unit_a,
  output logic [OP_W-1:0]  unit_b,
  input  logic             unit_done,
  input  logic [RES_W-1:0] unit_res,
  output logic             alu_grant,
  output logic             stall,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic             timeout_q, timeout_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    wb_addr_d = wb_addr_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          rd_d    = issue_rd;
          a_d     = issue_a;
          b_d     = issue_b;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion in the expiry cycle still delivers the real result.
        if (unit_done) begin
          res_d     = unit_res;
          wb_addr_d = rd_q;
          state_d   = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          res_d     = '1;
          timeout_d = 1'b1;
          wb_addr_d = rd_q;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      wb_addr_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      wb_addr_q <= wb_addr_d;
      timeout_q <= timeout_d;
    end
  end

  // Control outputs decode from the state; IDLE stalls the PC as soon as the decoder flags issue.
  always_comb begin
    unit_start = 1'b0;
    alu_grant  = 1'b0;
    stall      = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      S_IDLE:   stall = issue;
      S_LAUNCH: begin
        unit_start = 1'b1;
        alu_grant  = 1'b1;
        stall      = 1'b1;
      end
      S_WAIT: begin
        alu_grant = 1'b1;
        stall     = 1'b1;
      end
      S_WB:     wb_en = 1'b1;
      default:  ;
    endcase
  end

  assign unit_a  = a_q;
  assign unit_b  = b_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = 32'(res_q);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sr_mc_sequencer.sv
// Scoreboard bench for sr_mc_sequencer: stimulus pushes expected writes, a negedge
// monitor pops and compares every wb_en pulse.
module tb_sr_mc_sequencer;
  localparam int OP_W    = 8;
  localparam int RES_W   = 9;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic             clk;
  logic             rst;
  logic             issue;
  logic [4:0]       issue_rd;
  logic [OP_W-1:0]  issue_a;
  logic [OP_W-1:0]  issue_b;
  logic             unit_start;
  logic [OP_W-1:0]  unit_a;
  logic [OP_W-1:0]  unit_b;
  logic             unit_done;
  logic [RES_W-1:0] unit_res;
  logic             alu_grant;
  logic             stall;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             timeout;

  sr_mc_sequencer #(
    .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue(issue), .issue_rd(issue_rd), .issue_a(issue_a), .issue_b(issue_b),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_res(unit_res),
    .alu_grant(alu_grant), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [36:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", wb_en, 0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_addr", wb_addr, e[36:32]);
        check("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // One multi-cycle instruction issued in an IDLE cycle. n_wait<0 means unit_done never comes.
  task automatic do_op(input logic [4:0] rd, input logic [7:0] a, input logic [7:0] b,
                       input int n_wait, input logic [8:0] res, input bit hold,
                       input bit done_in_launch, input string tag);
    int wb_c;
    int grants;
    int starts;
    int exp_wb;
    logic [31:0] exp_data;
    exp_data = (n_wait < 0) ? 32'h0000_01FF : {23'b0, res};
    exp_wb   = (n_wait < 0) ? TIMEOUT + 2 : n_wait + 2;
    exp_q.push_back({rd, exp_data});
    issue = 1'b1; issue_rd = rd; issue_a = a; issue_b = b;
    @(negedge clk);
    check({tag, "_idle_stall"}, stall, 1);
    check({tag, "_idle_start"}, unit_start, 0);
    check({tag, "_idle_wb"}, wb_en, 0);
    @(posedge clk); #1;
    if (!hold) begin
      issue = 1'b0; issue_rd = ~rd; issue_a = ~a; issue_b = ~b;
    end
    wb_c = -1; grants = 0; starts = 0;
    for (int c = 1; c < 200; c++) begin
      unit_done = (done_in_launch && c == 1) || (n_wait > 0 && c == n_wait + 1);
      unit_res  = (c == 1) ? 9'h0AA : res;
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_unit_a"}, unit_a, a);
        check({tag, "_unit_b"}, unit_b, b);
      end
      grants += int'(alu_grant);
      starts += int'(unit_start);
      if (wb_en === 1'b1) begin
        wb_c = c;
        check({tag, "_wb_stall"}, stall, 0);
        check({tag, "_wb_grant"}, alu_grant, 0);
        check({tag, "_wb_unit_a"}, unit_a, a);
        break;
      end
      check({tag, "_busy_stall"}, stall, 1);
      @(posedge clk); #1;
    end
    unit_done = 1'b0;
    check({tag, "_wb_cycle"}, wb_c, exp_wb);
    check({tag, "_grant_cycles"}, grants, exp_wb - 1);
    check({tag, "_start_pulses"}, starts, 1);
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      check({tag, "_post_wb_start"}, unit_start, 0);
      check({tag, "_post_wb_grant"}, alu_grant, 0);
      issue = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_no_relaunch"}, unit_start, 0);
      check({tag, "_no_relaunch_wb"}, wb_en, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; issue_rd = '0; issue_a = '0; issue_b = '0;
    unit_done = 1'b0; unit_res = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_start", unit_start, 0);
    check("rst_grant", alu_grant, 0);
    check("rst_stall", stall, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_unit_a", unit_a, 0);
    check("rst_unit_b", unit_b, 0);
    check("rst_timeout", timeout, 0);
    @(posedge clk); #1;

    do_op(5'd5, 8'd3, 8'd4, 1, 9'd5, 1'b0, 1'b0, "t1_min");
    do_op(5'd7, 8'h12, 8'h34, 10, 9'h1FF, 1'b0, 1'b1, "t2_ten");
    do_op(5'd3, 8'h56, 8'h78, TIMEOUT, 9'h123, 1'b0, 1'b0, "race");
    check("race_timeout", timeout, 0);
    do_op(5'd4, 8'h9A, 8'hBC, -1, 9'h000, 1'b0, 1'b0, "t3_tmo");
    check("tmo_sticky", timeout, 1);
    do_op(5'd1, 8'h01, 8'h02, 2, 9'h011, 1'b0, 1'b0, "t5_b2b1");
    do_op(5'd2, 8'h03, 8'h04, 3, 9'h022, 1'b0, 1'b0, "t5_b2b2");
    check("tmo_still_set", timeout, 1);
    do_op(5'd6, 8'hA5, 8'h5A, 1, 9'h066, 1'b1, 1'b0, "t6_hold");
    do_op(5'd0, 8'h0F, 8'hF0, 1, 9'h100, 1'b0, 1'b0, "rd0");

    // Reset in the middle of WAIT abandons the operation.
    issue = 1'b1; issue_rd = 5'd9; issue_a = 8'h11; issue_b = 8'h22;
    @(posedge clk); #1 issue = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wb", wb_en, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_grant", alu_grant, 0);
    check("mid_rst_start", unit_start, 0);
    check("mid_rst_unit_a", unit_a, 0);
    check("mid_rst_timeout", timeout, 0);
    @(posedge clk); #1 unit_done = 1'b1; unit_res = 9'h077;
    @(posedge clk); #1 unit_done = 1'b0;
    @(negedge clk);
    check("late_done_wb", wb_en, 0);
    check("late_done_grant", alu_grant, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
